mux_nto1_rr_reg: RTL and testbench
==================================

Name: mux_nto1_rr_reg

Overview:
- Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshake; next generation of the team's 2:1 select mux.
- Two modes: explicit select (sel port, as the 2:1 mux) or round-robin arbitration among valid channels.
- Sits between multiple ALU operand/result sources and a single downstream consumer.
- Output is registered: one stage, full throughput.

Parameters:
- WIDTH, 8, data width per channel.
- NUM_CH, 4, number of input channels (>=1, need not be a power of 2).
- SEL_W, derived localparam = max(1, clog2(NUM_CH)), not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = explicit select, 1 = round-robin.
- sel  input  SEL_W  channel index used in mode 0.
- in_data  input  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready; combinational, at most one bit high.
- out_data  output  WIDTH  registered data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0. in_ready=0 while rst=1.
- load = !out_valid | out_ready (register empty or draining this cycle).
- Grant g (combinational):
  - mode 0: g=sel if sel<NUM_CH and in_valid[sel]; otherwise no grant. sel>=NUM_CH always gives no grant.
  - mode 1: first k with in_valid[k]=1, scanning ptr, ptr+1, ..., NUM_CH-1, 0, ..., ptr-1; no grant if in_valid=0.
- in_ready[k] = load & grant_valid & (k==g). A transfer on channel k is in_valid[k] & in_ready[k].
- At a clk edge with load=1:
  - grant present: out_data<=in_data[g], out_ch<=g, out_valid<=1.
  - no grant: out_valid<=0; out_data and out_ch hold.
- At a clk edge with load=0 (out_valid=1, out_ready=0): out_data, out_ch and out_valid hold stable, and no input is accepted.
- Pointer:
  - Updates only on an input transfer, in either mode: ptr <= (g==NUM_CH-1) ? 0 : g+1.
  - Otherwise ptr holds. A mode change does not alter ptr.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 transfer per cycle when out_ready is held at 1.
- Simultaneous drain and fill (out_valid=1, out_ready=1, grant present): the new word replaces the old at the same edge, with no bubble.
- Reset mid-operation: the pending output word is discarded, and out_valid=0 on the following cycle.
- NUM_CH=1: sel is ignored except for the sel<NUM_CH check (sel must be 0); the round-robin pointer stays at 0.
- in_data and in_valid of non-granted channels have no effect. No combinational path from out_ready to out_data.

Decomposition:
- Shared package (alu_pkg):
  - MODE_SEL=1'b0, MODE_RR=1'b1.
  - clog2 function used to derive SEL_W.
- One sub-module: rr_arbiter.
  - Parameter NUM_CH. Inputs: clk, rst, req[NUM_CH], advance. Outputs: grant index, grant_valid.
  - Holds ptr and performs the cyclic priority scan.
- Top level adds the mode 0 select path, the handshake and the output register.

Test Plan (WIDTH=8, NUM_CH=4):
1. Reset: rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0000; the first cycle after rst drops grants channel 0 (mode 1).
2. Mode 0, sel=2, in_data ch2=0xA5, in_valid=0100, out_ready=1 -> in_ready=0100; next cycle out_data=0xA5, out_ch=2, out_valid=1. Then sel=3 with in_valid[3]=0 -> in_ready=0000, and out_valid falls to 0.
3. Mode 1, all four valid, constant data ch k = 0x10+k, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, one word every cycle.
4. Mode 1, in_valid=1010, ptr=2 -> grant 3, then 1, then 3; channels 0 and 2 are never granted.
5. Backpressure: out_valid=1 with out_data=0x3C, out_ready=0 for 3 cycles, new inputs valid -> out_data stays 0x3C, in_ready=0000, ptr unchanged. When out_ready=1, the next word loads at the same edge.
6. Edge cases: mode 0 with sel=3 for NUM_CH=3 -> no grant ever. Assert rst while out_valid=1 -> out_valid=0 the following cycle, and ptr returns to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand/result multiplexer family.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents: mode encodings and a ceil-log2 helper used to size channel-index
// fields (never narrower than one bit, so a single-channel build still has a
// legal select/index port).
package alu_pkg;

  localparam logic MODE_SEL = 1'b0;  // explicit channel select
  localparam logic MODE_RR  = 1'b1;  // round-robin among valid channels

  // Ceiling log2 for elaboration-time sizing; bounded loop keeps it static.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Width of a channel-index field for n channels (minimum 1 bit).
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mux_nto1_rr_reg_arb.sv
// Round-robin arbiter: cyclic priority scan starting at a held pointer.
// Latency: combinational grant; pointer updates at the clock edge.
// Backpressure: pointer moves only when the caller reports a transfer.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   req           per-channel request vector
//   advance       a transfer happened this cycle
//   adv_ch        index of the channel that transferred (pointer moves past it)
//   grant         winning channel index (valid when grant_valid)
//   grant_valid   at least one request present
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int  NUM_CH = 4,
  localparam int SEL_W  = sel_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  input  logic [SEL_W-1:0]  adv_ch,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_valid
);

  localparam logic [SEL_W:0]   NCH  = (SEL_W + 1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);

  logic [SEL_W-1:0]  r_ptr;
  logic [NUM_CH-1:0] w_rot;
  logic [SEL_W-1:0]  w_off;
  logic [SEL_W:0]    w_sum;

  // Rotate requests so the pointer channel lands at bit 0; the lowest set
  // bit of the rotated vector is then the offset of the winner from ptr.
  assign w_rot = NUM_CH'({req, req} >> r_ptr);

  always_comb begin
    w_off = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = SEL_W'(i);
    end
  end

  // Map the offset back to an absolute index, wrapping modulo NUM_CH
  // (NUM_CH need not be a power of two, so plain truncation is not enough).
  assign w_sum       = {1'b0, r_ptr} + {1'b0, w_off};
  assign grant       = (w_sum >= NCH) ? SEL_W'(w_sum - NCH) : w_sum[SEL_W-1:0];
  assign grant_valid = |req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= (adv_ch == LAST) ? '0 : adv_ch + 1'b1;
    end
  end

endmodule

// File: rtl/mux_nto1_rr_reg.sv
// N-to-1 registered mux with per-channel valid/ready; explicit-select or round-robin.
// Latency: 1 cycle from input transfer to out_valid; 1 word/cycle with out_ready high.
// Backpressure: register holds and all in_ready drop while out_valid & !out_ready.
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   mode        0 = explicit select via sel, 1 = round-robin
//   sel         channel index used in select mode
//   in_data     channel k at [k*WIDTH +: WIDTH]
//   in_valid    per-channel valid
//   in_ready    per-channel ready, one-hot or zero, combinational
//   out_data    registered data
//   out_ch      index of the channel that supplied out_data
//   out_valid   registered valid
//   out_ready   downstream ready
module mux_nto1_rr_reg
  import alu_pkg::*;
#(
  parameter int  WIDTH  = 8,
  parameter int  NUM_CH = 4,
  localparam int SEL_W  = sel_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [SEL_W:0] NCH = (SEL_W + 1)'(NUM_CH);

  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_ch;
  logic             r_out_valid;

  logic             w_load;
  logic             w_sel_ok;
  logic             w_sel_gv;
  logic             w_arb_gv;
  logic [SEL_W-1:0] w_arb_g;
  logic             w_gv;
  logic [SEL_W-1:0] w_g;
  logic             w_xfer;
  logic [WIDTH-1:0] w_mux;

  // Register can accept a word when empty or being drained this cycle.
  // out_ready only gates acceptance; it never reaches out_data combinationally.
  assign w_load = !r_out_valid | out_ready;

  // Select path: an out-of-range sel (possible when NUM_CH is not a power
  // of two) never grants.
  assign w_sel_ok = ({1'b0, sel} < NCH);
  assign w_sel_gv = w_sel_ok & (|(in_valid & (NUM_CH'(1) << sel)));

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (in_valid),
    .advance     (w_xfer),
    .adv_ch      (w_g),
    .grant       (w_arb_g),
    .grant_valid (w_arb_gv)
  );

  assign w_g  = (mode == MODE_RR) ? w_arb_g  : sel;
  assign w_gv = (mode == MODE_RR) ? w_arb_gv : w_sel_gv;

  // A transfer also advances the round-robin pointer in select mode, so a
  // later switch to round-robin resumes after the last channel served.
  assign w_xfer   = w_load & w_gv & !rst;
  assign in_ready = w_xfer ? (NUM_CH'(1) << w_g) : '0;

  assign w_mux = WIDTH'(in_data >> (w_g * WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      if (w_gv) begin
        r_out_data  <= w_mux;
        r_out_ch    <= w_g;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_nto1_rr_reg.sv
// Directed bench for mux_nto1_rr_reg (4-channel main instance, 3-channel edge instance).
// Latency: n/a.
// Backpressure: exercised directly via out_ready.
module tb_mux_nto1_rr_reg;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  logic        mode3;
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        out_ready3;

  int n_cmp;
  int n_err;

  localparam logic [31:0] BASE_DATA = {8'h13, 8'h12, 8'h11, 8'h10};

  mux_nto1_rr_reg #(.WIDTH(8), .NUM_CH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_nto1_rr_reg #(.WIDTH(8), .NUM_CH(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode3),
    .sel       (sel3),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_ch    (out_ch3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; sel = 2'd0;
    in_data = BASE_DATA; in_valid = 4'b1111; out_ready = 1'b1;
    step();
    step();
    n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_cmp++; if (out_ch !== 2'd0) begin n_err++; $display("FAIL reset_out_ch: got %0d want 0", out_ch); end
    n_cmp++; if (out_valid3 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid3: got %b want 0", out_valid3); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant: got %b want 0001", in_ready); end
    step();
    n_cmp++; if (out_ch !== 2'd0) begin n_err++; $display("FAIL reset_first_ch: got %0d want 0", out_ch); end
    n_cmp++; if (out_data !== 8'h10) begin n_err++; $display("FAIL reset_first_data: got %h want 10", out_data); end
  endtask

  task automatic test_mode0();
    mode = 1'b0; sel = 2'd2;
    in_data = {8'h13, 8'hA5, 8'h11, 8'h10}; in_valid = 4'b0100; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL sel2_in_ready: got %b want 0100", in_ready); end
    step();
    n_cmp++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL sel2_out_data: got %h want a5", out_data); end
    n_cmp++; if (out_ch !== 2'd2) begin n_err++; $display("FAIL sel2_out_ch: got %0d want 2", out_ch); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sel2_out_valid: got %b want 1", out_valid); end
    sel = 2'd3;
    #1;
    n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL sel3_in_ready: got %b want 0000", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sel3_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL sel3_data_hold: got %h want a5", out_data); end
  endtask

  task automatic test_rr_all();
    logic [1:0] exp_ch [5];
    exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b1;
    step();
    rst = 1'b0;
    mode = 1'b1; in_data = BASE_DATA; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (in_ready !== (4'b0001 << exp_ch[i])) begin n_err++; $display("FAIL rr_all_in_ready[%0d]: got %b want ch %0d", i, in_ready, exp_ch[i]); end
      step();
      n_cmp++; if (out_ch !== exp_ch[i]) begin n_err++; $display("FAIL rr_all_out_ch[%0d]: got %0d want %0d", i, out_ch, exp_ch[i]); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rr_all_out_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== (8'h10 + 8'(exp_ch[i]))) begin n_err++; $display("FAIL rr_all_out_data[%0d]: got %h want %h", i, out_data, 8'h10 + 8'(exp_ch[i])); end
    end
  endtask

  task automatic test_rr_sparse();
    logic [1:0] exp_ch [3];
    exp_ch = '{2'd3, 2'd1, 2'd3};
    // Pointer sits at 1 here; a lone ch1 transfer moves it to 2.
    in_valid = 4'b0010;
    #1;
    n_cmp++; if (in_ready !== 4'b0010) begin n_err++; $display("FAIL sparse_setup_in_ready: got %b want 0010", in_ready); end
    step();
    n_cmp++; if (out_ch !== 2'd1) begin n_err++; $display("FAIL sparse_setup_ch: got %0d want 1", out_ch); end
    in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (in_ready !== (4'b0001 << exp_ch[i])) begin n_err++; $display("FAIL sparse_in_ready[%0d]: got %b want ch %0d", i, in_ready, exp_ch[i]); end
      step();
      n_cmp++; if (out_ch !== exp_ch[i]) begin n_err++; $display("FAIL sparse_out_ch[%0d]: got %0d want %0d", i, out_ch, exp_ch[i]); end
      n_cmp++; if (out_data !== (8'h10 + 8'(exp_ch[i]))) begin n_err++; $display("FAIL sparse_out_data[%0d]: got %h want %h", i, out_data, 8'h10 + 8'(exp_ch[i])); end
    end
  endtask

  task automatic test_backpressure();
    // Pointer is 0; load 0x3C through ch1 in select mode (pointer -> 2).
    mode = 1'b0; sel = 2'd1;
    in_data = {8'h13, 8'h12, 8'h3C, 8'h10}; in_valid = 4'b0010; out_ready = 1'b1;
    step();
    n_cmp++; if (out_data !== 8'h3C) begin n_err++; $display("FAIL bp_load: got %h want 3c", out_data); end
    mode = 1'b1; in_data = BASE_DATA; in_valid = 4'b1111; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", i, in_ready); end
      step();
      n_cmp++; if (out_data !== 8'h3C) begin n_err++; $display("FAIL bp_hold_data[%0d]: got %h want 3c", i, out_data); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (out_ch !== 2'd1) begin n_err++; $display("FAIL bp_hold_ch[%0d]: got %0d want 1", i, out_ch); end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL bp_release_in_ready: got %b want 0100", in_ready); end
    step();
    n_cmp++; if (out_data !== 8'h12) begin n_err++; $display("FAIL bp_release_data: got %h want 12", out_data); end
    n_cmp++; if (out_ch !== 2'd2) begin n_err++; $display("FAIL bp_release_ch: got %0d want 2", out_ch); end
  endtask

  task automatic test_edge();
    mode3 = 1'b0; sel3 = 2'd3; in_data3 = {8'h77, 8'h66, 8'h55};
    in_valid3 = 3'b111; out_ready3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (in_ready3 !== 3'b000) begin n_err++; $display("FAIL nch3_sel3_in_ready[%0d]: got %b want 000", i, in_ready3); end
      step();
      n_cmp++; if (out_valid3 !== 1'b0) begin n_err++; $display("FAIL nch3_sel3_out_valid[%0d]: got %b want 0", i, out_valid3); end
    end
    sel3 = 2'd2;
    #1;
    n_cmp++; if (in_ready3 !== 3'b100) begin n_err++; $display("FAIL nch3_sel2_in_ready: got %b want 100", in_ready3); end
    step();
    n_cmp++; if (out_data3 !== 8'h77) begin n_err++; $display("FAIL nch3_sel2_data: got %h want 77", out_data3); end
    n_cmp++; if (out_ch3 !== 2'd2) begin n_err++; $display("FAIL nch3_sel2_ch: got %0d want 2", out_ch3); end
    // Main instance holds a word (ch2) with pointer at 3; reset mid-operation.
    out_ready = 1'b0; rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL midrst_in_ready: got %b want 0000", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL midrst_out_data: got %h want 00", out_data); end
    rst = 1'b0; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL midrst_ptr_in_ready: got %b want 0001", in_ready); end
    step();
    n_cmp++; if (out_ch !== 2'd0) begin n_err++; $display("FAIL midrst_ptr_ch: got %0d want 0", out_ch); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
    mode3 = 1'b0; sel3 = '0; in_data3 = '0; in_valid3 = '0; out_ready3 = 1'b1;
    test_reset();
    test_mode0();
    test_rr_all();
    test_rr_sparse();
    test_backpressure();
    test_edge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
